// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - streams words from a valid/ready source into a RAM override write port
//
// Purpose: on an accepted start, writes word_count words from in_data into
// consecutive RAM addresses starting at base_addr, wrapping at 2^ADDR_WIDTH.
// Optional readback checking is enabled by defining MEM_LOADER_VERIFY_EN.
//
// Ports:
//   Clock            in   system clock, rising edge
//   clear            in   asynchronous active-low reset
//   start            in   load request, sampled only in IDLE
//   base_addr        in   first RAM address
//   word_count       in   number of words to load (0..2^ADDR_WIDTH)
//   in_valid/in_data in   source word handshake
//   in_ready         out  loader is in LOAD and will take in_data
//   overide*         out  registered RAM override write strobe/address/data
//   rd_en/rd_addr    out  registered RAM readback request (verify build only)
//   rd_data          in   RAM read data, one cycle after rd_en
//   busy             out  load in progress (held through the done pulse)
//   done             out  one-cycle completion pulse
//   error            out  sticky readback mismatch (verify build only)
`timescale 1ns/1ps

module mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  overide,
    output logic [ADDR_WIDTH-1:0] overide_address,
    output logic [DATA_WIDTH-1:0] overide_data_in,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
`ifdef MEM_LOADER_VERIFY_EN
        ,
        S_VRD   = 3'd4,
        S_VCMP  = 3'd5
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  overide_q, overide_d;
    logic [ADDR_WIDTH-1:0] overide_address_q, overide_address_d;
    logic [DATA_WIDTH-1:0] overide_data_in_q, overide_data_in_d;
    logic                  done_q, done_d;

    // Count after retiring the current word; saturates so it can never underflow.
    logic [ADDR_WIDTH:0]   rem_dec;
    state_t                after_word;

    assign rem_dec    = (rem_q != '0) ? rem_q - 1'b1 : '0;
    assign after_word = (rem_dec != '0) ? S_LOAD : S_DONE;

`ifdef MEM_LOADER_VERIFY_EN
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  error_q, error_d;
`endif

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        rem_d             = rem_q;
        overide_d         = 1'b0;
        overide_address_d = overide_address_q;
        overide_data_in_d = overide_data_in_q;
        done_d            = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
        rd_en_d           = 1'b0;
        rd_addr_d         = rd_addr_q;
        error_d           = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_count;
`ifdef MEM_LOADER_VERIFY_EN
                    error_d = 1'b0;
`endif
                    state_d = (word_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    overide_d         = 1'b1;
                    overide_address_d = addr_q;
                    overide_data_in_d = in_data;
                    state_d           = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef MEM_LOADER_VERIFY_EN
                // Issue the read here so rd_en is high during VRD and the
                // RAM answers in VCMP; the write lands at the end of WRITE.
                rd_en_d   = 1'b1;
                rd_addr_d = addr_q;
                state_d   = S_VRD;
`else
                addr_d    = addr_q + 1'b1;
                rem_d     = rem_dec;
                state_d   = after_word;
`endif
            end
`ifdef MEM_LOADER_VERIFY_EN
            S_VRD: begin
                state_d = S_VCMP;
            end
            S_VCMP: begin
                // overide_data_in_q still holds the word just written.
                if (rd_data != overide_data_in_q) begin
                    error_d = 1'b1;
                end
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_dec;
                state_d = after_word;
            end
`endif
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q           <= S_IDLE;
            addr_q            <= '0;
            rem_q             <= '0;
            overide_q         <= 1'b0;
            overide_address_q <= '0;
            overide_data_in_q <= '0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            rem_q             <= rem_d;
            overide_q         <= overide_d;
            overide_address_q <= overide_address_d;
            overide_data_in_q <= overide_data_in_d;
            done_q            <= done_d;
        end
    end

`ifdef MEM_LOADER_VERIFY_EN
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            error_q   <= 1'b0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            error_q   <= error_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign error   = error_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
    assign rd_en          = 1'b0;
    assign rd_addr        = '0;
    assign error          = 1'b0;
`endif

    assign in_ready        = (state_q == S_LOAD);
    assign overide         = overide_q;
    assign overide_address = overide_address_q;
    assign overide_data_in = overide_data_in_q;
    assign done            = done_q;
    // done is registered out of DONE, so busy is extended to fall with it.
    assign busy            = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader with a RAM model and write scoreboard
`timescale 1ns/1ps

module tb_mem_loader;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
`ifdef MEM_LOADER_VERIFY_EN
    localparam int STEP  = 4;
`else
    localparam int STEP  = 2;
`endif

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          overide;
    logic [AW-1:0] overide_address;
    logic [DW-1:0] overide_data_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock           (clk),
        .clear           (clear),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .overide         (overide),
        .overide_address (overide_address),
        .overide_data_in (overide_data_in),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    // RAM model with optional read corruption of one address.
    logic [DW-1:0] ram [DEPTH];
    bit            corrupt_en   = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (overide) ram[overide_address] <= overide_data_in;
        if (rd_en)   rd_data <= ram[rd_addr] ^ ((corrupt_en && rd_addr == corrupt_addr) ? 32'h1 : 32'h0);
    end

    // Monitor: records every write and done pulse shortly after each rising edge.
    int            cyc = 0;
    int            wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            overlap  = 0;
    int            rd_seen  = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (overide) begin
            wr_addr_q.push_back(int'(overide_address));
            wr_data_q.push_back(overide_data_in);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (overide && rd_en) overlap++;
        if (rd_en) rd_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_overide"}, overide, 0);
        check({tag, "_overide_address"}, overide_address, 0);
        check({tag, "_overide_data_in"}, overide_data_in, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    logic [DW-1:0] src [DEPTH];

    // vmode: 0 = in_valid held, 1 = toggled, 2 = random.
    task automatic do_load(input int base, input int wc, input int vmode,
                           input bit glitch, input int abort_at, input bit corrupt);
        int idx = 0;
        int sc;
        bit finished = 1'b0;
        int exp_err;
        for (int i = 0; i < DEPTH; i++) src[i] = $urandom;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt     = 0;
        corrupt_en   = corrupt;
        corrupt_addr = AW'((base + 1) % DEPTH);

        @(negedge clk);
        base_addr  = AW'(base);
        word_count = (AW+1)'(wc);
        start      = 1'b1;
        in_valid   = 1'b0;
        sc         = cyc;
        @(negedge clk);
        start = 1'b0;

        for (int n = 0; n < 4000; n++) begin
            if (done_cnt != 0) begin
                finished = 1'b1;
                break;
            end
            if (abort_at > 0 && wr_addr_q.size() >= abort_at) break;
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = n[0];
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = src[(idx < DEPTH) ? idx : DEPTH - 1];
            if (glitch && n == 3) begin
                start      = 1'b1;
                base_addr  = AW'(base + 7);
                word_count = (AW+1)'(wc + 3);
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        start = 1'b0;

        if (abort_at > 0) begin
            check("abort_reached", wr_addr_q.size(), abort_at);
            #2 clear = 1'b0;
            #1 check_reset("abort_async");
            in_valid = 1'b1;
            repeat (4) @(negedge clk);
            check("abort_no_more_writes", wr_addr_q.size(), abort_at);
            check("abort_busy_low", busy, 0);
            in_valid = 1'b0;
            clear    = 1'b1;
            return;
        end

        in_valid = 1'b0;
        check("done_seen", finished, 1);
        check("busy_with_done", {busy, done}, 2'b11);
        @(negedge clk);
        check("busy_falls_with_done", {busy, done}, 2'b00);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("write_count", wr_addr_q.size(), wc);
        for (int i = 0; i < wc && i < wr_addr_q.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], (base + i) % DEPTH);
            check($sformatf("wr_data[%0d]", i), wr_data_q[i], src[i]);
            if (vmode == 0 && i > 0)
                check($sformatf("wr_spacing[%0d]", i), wr_cyc_q[i] - wr_cyc_q[i-1], STEP);
        end
        if (wc == 0) check("zero_done_latency", done_cyc - sc, 2);
`ifdef MEM_LOADER_VERIFY_EN
        exp_err = corrupt ? 1 : 0;
`else
        exp_err = 0;
`endif
        check("error_after_load", error, exp_err);
    endtask

    initial begin
        clear      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        clear = 1'b1;

        // Fixed three-word load with known words.
        begin
            wr_addr_q.delete();
            wr_data_q.delete();
            wr_cyc_q.delete();
            done_cnt = 0;
            @(negedge clk);
            base_addr  = 9'h010;
            word_count = 10'd3;
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                in_valid = 1'b1;
                in_data  = 32'hA + 32'(k);
                for (int t = 0; t < 10 && !in_ready; t++) @(negedge clk);
                @(negedge clk);
            end
            in_valid = 1'b0;
            for (int t = 0; t < 20 && done_cnt == 0; t++) @(negedge clk);
            check("fixed_done_busy", {busy, done}, 2'b11);
            @(negedge clk);
            check("fixed_busy_falls", busy, 0);
            check("fixed_writes", wr_addr_q.size(), 3);
            for (int k = 0; k < 3 && k < wr_addr_q.size(); k++) begin
                check($sformatf("fixed_addr[%0d]", k), wr_addr_q[k], 16 + k);
                check($sformatf("fixed_data[%0d]", k), wr_data_q[k], 32'hA + 32'(k));
            end
            check("fixed_done_cnt", done_cnt, 1);
        end

        do_load(9'h1FF, 2, 0, 1'b0, 0, 1'b0);   // wrap-around
        do_load(9'h055, 0, 0, 1'b0, 0, 1'b0);   // empty load
        do_load(9'h120, 5, 1, 1'b1, 0, 1'b0);   // toggled valid, stray start
        do_load(9'h0F0, 4, 0, 1'b0, 2, 1'b0);   // abort after two writes
        do_load(9'h0F0, 4, 0, 1'b0, 0, 1'b0);   // normal load after abort
        for (int r = 0; r < 3; r++)
            do_load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)), 2, 1'b0, 0, 1'b0);
        do_load(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 1'b0, 0, 1'b0);

`ifdef MEM_LOADER_VERIFY_EN
        do_load(9'h040, 4, 0, 1'b0, 0, 1'b1);   // corrupted readback of word 2
        @(negedge clk);
        word_count = '0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("error_cleared_by_start", error, 0);
        repeat (4) @(negedge clk);
        check("rd_en_seen", rd_seen > 0, 1);
`else
        check("rd_en_never", rd_seen, 0);
`endif
        check("no_overide_rd_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
